// File: rtl/booth_mult_pipe.sv
// rtl/booth_mult_pipe.sv - pipelined radix-4 Booth multiplier, two's-complement or sign-magnitude operands
// Optional feature macro: BOOTH_MULT_SAT_EN (saturate out_result on overflow instead of wrapping)
module booth_mult_pipe #(
    parameter int A_W   = 11,
    parameter int B_W   = 8,
    parameter int OUT_W = A_W + B_W,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_fmt,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_result,
    output logic             out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf
);
    localparam int P_W  = A_W + B_W;
    localparam int BE_W = B_W + (B_W % 2);
    localparam int NPP  = BE_W / 2;
    localparam int LVL  = $clog2(NPP);

    function automatic int cnt_f(input int l);
        return (NPP + (1 << l) - 1) >> l;
    endfunction

    function automatic int off_f(input int l);
        int s;
        s = 0;
        for (int k = 0; k < l; k++) s += cnt_f(k);
        return s;
    endfunction

    // All adder-tree levels share one flat array; level l starts at off_f(l)
    localparam int TOT = off_f(LVL + 1);

    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    logic [A_W-1:0]  w_a_tc;
    logic [B_W-1:0]  w_b_tc;
    logic [P_W-1:0]  w_a_ext;
    logic [BE_W-1:0] w_b_se;
    logic [BE_W:0]   w_bx;
    logic [P_W-1:0]  w_pp [NPP];

    always_comb begin
        w_a_tc = in_a;
        w_b_tc = in_b;
        if (in_fmt) begin
            w_a_tc = in_a[A_W-1] ? -{1'b0, in_a[A_W-2:0]} : {1'b0, in_a[A_W-2:0]};
            w_b_tc = in_b[B_W-1] ? -{1'b0, in_b[B_W-2:0]} : {1'b0, in_b[B_W-2:0]};
        end
    end

    assign w_a_ext = P_W'($signed(w_a_tc));
    assign w_b_se  = BE_W'($signed(w_b_tc));
    assign w_bx    = {w_b_se, 1'b0};

    always_comb begin
        for (int i = 0; i < NPP; i++) begin
            case (w_bx[2*i +: 3])
                3'b001, 3'b010: w_pp[i] = w_a_ext;
                3'b011:         w_pp[i] = w_a_ext << 1;
                3'b100:         w_pp[i] = -(w_a_ext << 1);
                3'b101, 3'b110: w_pp[i] = -w_a_ext;
                default:        w_pp[i] = '0;
            endcase
            w_pp[i] = w_pp[i] << (2 * i);
        end
    end

    logic [P_W-1:0]   r_tree [TOT];
    logic [LVL:0]     r_vld;
    logic [LVL:0]     r_fmt;
    logic [TAG_W-1:0] r_tag [LVL+1];

    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int i = 0; i < NPP; i++) r_tree[i] <= w_pp[i];
            for (int l = 1; l <= LVL; l++) begin
                for (int j = 0; j < cnt_f(l); j++) begin
                    if (2 * j + 1 < cnt_f(l - 1))
                        r_tree[off_f(l) + j] <= r_tree[off_f(l - 1) + 2 * j]
                                              + r_tree[off_f(l - 1) + 2 * j + 1];
                    else
                        r_tree[off_f(l) + j] <= r_tree[off_f(l - 1) + 2 * j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_fmt <= '0;
            for (int s = 0; s <= LVL; s++) r_tag[s] <= '0;
        end else if (w_en) begin
            r_vld[0] <= in_valid;
            r_fmt[0] <= in_fmt;
            r_tag[0] <= in_tag;
            for (int s = 1; s <= LVL; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_fmt[s] <= r_fmt[s-1];
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    logic [P_W-1:0]   w_p;
    logic [P_W-1:0]   w_mag;
    logic             w_neg;
    logic             w_ovf;
    logic [OUT_W-1:0] w_res;

    always_comb begin
        w_p   = r_tree[TOT-1];
        w_neg = w_p[P_W-1];
        w_mag = w_neg ? -w_p : w_p;
        w_ovf = 1'b0;
        w_res = w_p[OUT_W-1:0];
        if (!r_fmt[LVL]) begin
            if (OUT_W < P_W)
                w_ovf = (w_p[P_W-1:OUT_W-1] != {(P_W-OUT_W+1){w_neg}});
`ifdef BOOTH_MULT_SAT_EN
            if (w_ovf)
                w_res = w_neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
`endif
        end else begin
            if (OUT_W < P_W)
                w_ovf = (w_mag[P_W-1:OUT_W-1] != '0);
            w_res = {1'b0, w_mag[OUT_W-2:0]};
`ifdef BOOTH_MULT_SAT_EN
            if (w_ovf)
                w_res[OUT_W-2:0] = {(OUT_W-1){1'b1}};
`endif
            // Sign follows the emitted magnitude so a zero field is never negative
            w_res[OUT_W-1] = w_neg && (w_res[OUT_W-2:0] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_fmt    <= 1'b0;
            out_tag    <= '0;
            out_ovf    <= 1'b0;
        end else if (w_en) begin
            out_valid  <= r_vld[LVL];
            out_result <= w_res;
            out_fmt    <= r_fmt[LVL];
            out_tag    <= r_tag[LVL];
            out_ovf    <= w_ovf;
        end
    end
endmodule

// File: tb/tb_booth_mult_pipe.sv
// tb/tb_booth_mult_pipe.sv - directed table-driven bench for booth_mult_pipe (default and OUT_W=16 builds)
module tb_booth_mult_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_fmt = 1'b0;
    logic [10:0] in_a = '0;
    logic [7:0]  in_b = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [18:0] out_result;
    logic        out_fmt;
    logic [3:0]  out_tag;
    logic        out_ovf;

    logic        in_valid_16 = 1'b0;
    logic        in_ready_16;
    logic        in_fmt_16 = 1'b0;
    logic [10:0] in_a_16 = '0;
    logic [7:0]  in_b_16 = '0;
    logic [3:0]  in_tag_16 = '0;
    logic        out_valid_16;
    logic        out_ready_16 = 1'b1;
    logic [15:0] out_result_16;
    logic        out_fmt_16;
    logic [3:0]  out_tag_16;
    logic        out_ovf_16;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    booth_mult_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_fmt(out_fmt), .out_tag(out_tag), .out_ovf(out_ovf)
    );

    booth_mult_pipe #(.OUT_W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_16), .in_ready(in_ready_16), .in_fmt(in_fmt_16),
        .in_a(in_a_16), .in_b(in_b_16), .in_tag(in_tag_16), .out_valid(out_valid_16),
        .out_ready(out_ready_16), .out_result(out_result_16), .out_fmt(out_fmt_16),
        .out_tag(out_tag_16), .out_ovf(out_ovf_16)
    );

    typedef struct {
        logic        fmt;
        logic [10:0] a;
        logic [7:0]  b;
        logic [18:0] res;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic        fmt;
        logic [10:0] a;
        logic [7:0]  b;
        logic [15:0] res_wrap;
        logic [15:0] res_sat;
        logic        ovf;
    } vec16_t;

    vec_t   vecs [12];
    vec16_t v16s [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic run_one(input int i, input logic [3:0] tag);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        in_fmt   = vecs[i].fmt;
        in_a     = vecs[i].a;
        in_b     = vecs[i].b;
        in_tag   = tag;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk($sformatf("lat_v%0d", i), 32'(lat), 32'd4);
        chk($sformatf("res_v%0d", i), 32'(out_result), 32'(vecs[i].res));
        chk($sformatf("ovf_v%0d", i), 32'(out_ovf), 32'(vecs[i].ovf));
        chk($sformatf("tag_v%0d", i), 32'(out_tag), 32'(tag));
        chk($sformatf("fmt_v%0d", i), 32'(out_fmt), 32'(vecs[i].fmt));
    endtask

    task automatic run16(input int i);
        int lat;
        logic [15:0] exp;
`ifdef BOOTH_MULT_SAT_EN
        exp = v16s[i].res_sat;
`else
        exp = v16s[i].res_wrap;
`endif
        @(negedge clk);
        in_valid_16 = 1'b1;
        in_fmt_16   = v16s[i].fmt;
        in_a_16     = v16s[i].a;
        in_b_16     = v16s[i].b;
        in_tag_16   = 4'(i);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid_16 = 1'b0;
        while (!out_valid_16 && lat < 12) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk($sformatf("w16_valid_%0d", i), 32'(out_valid_16), 32'd1);
        chk($sformatf("w16_res_%0d", i), 32'(out_result_16), 32'(exp));
        chk($sformatf("w16_ovf_%0d", i), 32'(out_ovf_16), 32'(v16s[i].ovf));
    endtask

    task automatic run_stream(input int stall_start, input int stall_len, input string nm);
        logic [18:0] q_res [$];
        logic [3:0]  q_tag [$];
        logic [18:0] snap_res;
        logic [3:0]  snap_tag;
        int idx = 0, got = 0, cyc = 0, first = -1, last = -1, last_acc = -1, extra = 0;
        snap_res = '0;
        snap_tag = '0;
        while (got < 8 && cyc < 100) begin
            @(negedge clk);
            out_ready = !(stall_len > 0 && cyc >= stall_start && cyc < stall_start + stall_len);
            #1;
            if (!out_ready) begin
                if (cyc == stall_start) begin
                    snap_res = out_result;
                    snap_tag = out_tag;
                end else begin
                    chk($sformatf("%s_hold_res_c%0d", nm, cyc), 32'(out_result), 32'(snap_res));
                    chk($sformatf("%s_hold_tag_c%0d", nm, cyc), 32'(out_tag), 32'(snap_tag));
                end
                chk($sformatf("%s_stall_valid_c%0d", nm, cyc), 32'(out_valid), 32'd1);
                chk($sformatf("%s_stall_in_ready_c%0d", nm, cyc), 32'(in_ready), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (q_res.size() == 0) begin
                    extra++;
                end else begin
                    chk($sformatf("%s_res_%0d", nm, got), 32'(out_result), 32'(q_res.pop_front()));
                    chk($sformatf("%s_tag_%0d", nm, got), 32'(out_tag), 32'(q_tag.pop_front()));
                    got++;
                    if (first < 0) first = cyc;
                    last = cyc;
                end
            end
            if (idx < 8) begin
                in_valid = 1'b1;
                in_fmt   = vecs[idx].fmt;
                in_a     = vecs[idx].a;
                in_b     = vecs[idx].b;
                in_tag   = 4'(idx + 1);
                if (in_ready) begin
                    q_res.push_back(vecs[idx].res);
                    q_tag.push_back(4'(idx + 1));
                    last_acc = cyc;
                    idx++;
                end
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({nm, "_count"}, 32'(got), 32'd8);
        chk({nm, "_extra"}, 32'(extra), 32'd0);
        if (stall_len == 0) begin
            chk({nm, "_out_span"}, 32'(last - first), 32'd7);
            chk({nm, "_acc_last"}, 32'(last_acc), 32'd7);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        chk({nm, "_no_dup"}, 32'(extra), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        vecs[0]  = '{1'b0, 11'h400, 8'h80, 19'h20000, 1'b0};
        vecs[1]  = '{1'b1, 11'h7FF, 8'h7F, 19'h5FB81, 1'b0};
        vecs[2]  = '{1'b1, 11'h400, 8'h85, 19'h00000, 1'b0};
        vecs[3]  = '{1'b0, 11'h3FF, 8'h7F, 19'h1FB81, 1'b0};
        vecs[4]  = '{1'b0, 11'h7FF, 8'h01, 19'h7FFFF, 1'b0};
        vecs[5]  = '{1'b0, 11'h400, 8'h7F, 19'h60400, 1'b0};
        vecs[6]  = '{1'b0, 11'h000, 8'h80, 19'h00000, 1'b0};
        vecs[7]  = '{1'b1, 11'h005, 8'h83, 19'h4000F, 1'b0};
        vecs[8]  = '{1'b1, 11'h3FF, 8'hFF, 19'h5FB81, 1'b0};
        vecs[9]  = '{1'b0, 11'h003, 8'hFD, 19'h7FFF7, 1'b0};
        vecs[10] = '{1'b1, 11'h000, 8'hFF, 19'h00000, 1'b0};
        vecs[11] = '{1'b0, 11'h400, 8'hFF, 19'h00400, 1'b0};

        v16s[0] = '{1'b0, 11'h3E8, 8'h64, 16'h86A0, 16'h7FFF, 1'b1};
        v16s[1] = '{1'b0, 11'h064, 8'h64, 16'h2710, 16'h2710, 1'b0};
        v16s[2] = '{1'b0, 11'h418, 8'h64, 16'h7960, 16'h8000, 1'b1};
        v16s[3] = '{1'b1, 11'h3E8, 8'hE4, 16'h86A0, 16'hFFFF, 1'b1};
        v16s[4] = '{1'b1, 11'h102, 8'hFF, 16'hFFFE, 16'hFFFE, 1'b0};
        v16s[5] = '{1'b0, 11'h100, 8'h80, 16'h8000, 16'h8000, 1'b0};
        v16s[6] = '{1'b0, 11'h700, 8'h80, 16'h8000, 16'h7FFF, 1'b1};
        v16s[7] = '{1'b1, 11'h102, 8'h7F, 16'h7FFE, 16'h7FFE, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 12; i++) run_one(i, 4'(i + 3));
        for (int i = 0; i < 8; i++) run16(i);

        run_stream(5, 10, "stall");
        run_stream(0, 0, "cont");

        @(negedge clk);
        in_valid = 1'b1; in_fmt = vecs[3].fmt; in_a = vecs[3].a; in_b = vecs[3].b; in_tag = 4'hA;
        @(negedge clk);
        in_fmt = vecs[5].fmt; in_a = vecs[5].a; in_b = vecs[5].b; in_tag = 4'hB;
        @(negedge clk);
        in_fmt = vecs[9].fmt; in_a = vecs[9].a; in_b = vecs[9].b; in_tag = 4'hC;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_result", 32'(out_result), 32'd0);
        chk("rst_mid_tag", 32'(out_tag), 32'd0);
        chk("rst_mid_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("rst_no_stale", 32'(stale), 32'd0);
        run_one(1, 4'h6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/booth_mult_pipe.md
# booth_mult_pipe

Parametrised, fully pipelined radix-4 Booth multiplier with valid/ready flow control and per-transaction operand format (two's complement or legacy sign-magnitude). It is the successor to the fixed 11x8 sign-magnitude datapath multiplier, and drops into the same datapath slot. Defaults reproduce the legacy 11x8 -> 19-bit sign-magnitude result. Accepts one product per cycle, and the whole pipeline stalls under back-pressure.

## Interface
Parameters:
- A_W, 11, width of operand a (>= 2)
- B_W, 8, width of operand b (>= 2; odd widths are sign-extended internally to even)
- OUT_W, A_W+B_W, result width (<= A_W+B_W)
- TAG_W, 4, sideband tag width, carried unchanged alongside its operands

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  stage 1 can accept operands
- in_fmt  in  1  0 = two's complement, 1 = sign-magnitude (MSB = sign)
- in_a  in  A_W  multiplicand
- in_b  in  B_W  multiplier (Booth-recoded)
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_result  out  OUT_W  product, in the format of its in_fmt
- out_fmt  out  1  in_fmt of this result
- out_tag  out  TAG_W  in_tag of this result
- out_ovf  out  1  product did not fit in OUT_W

## Operation
- P_W = A_W+B_W. NPP = ceil(B_W/2) partial products. LVL = ceil(log2(NPP)).
- Stage 1 (capture on in_valid && in_ready):
  - Sign-magnitude operands are converted to two's complement; -0 becomes 0.
  - b is radix-4 Booth recoded to digits {-2,-1,0,+1,+2}.
  - The NPP sign-extended partial products are registered.
- Stages 2..LVL+1: carry-propagate adder tree, one registered level per stage, pairwise; an odd leftover is passed through.
- Final stage, format conversion:
  - fmt 0: out_result is the two's-complement product.
  - fmt 1: out_result[OUT_W-1] is the sign and the lower bits hold the magnitude. The sign is forced to 0 when the magnitude is 0, so there is no negative zero.
- Overflow (OUT_W < P_W):
  - fmt 0: out_ovf = 1 when the product falls outside [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - fmt 1: out_ovf = 1 when the magnitude exceeds 2^(OUT_W-1)-1.
  - out_ovf is always 0 when OUT_W = P_W.
- Tag, fmt and valid bits travel with their data through every stage.
- Global stall: en = !out_valid || out_ready; in_ready = en.
  - When en = 0, no pipeline register (data or valid) changes.
  - Bubbles are not compressed while stalled; this is a deliberate simplicity trade-off.
- Results leave in acceptance order. No reordering, no drops, no duplicates.

## Timing
- Latency LAT = LVL+2 cycles from the accepting edge to out_valid, when unstalled. Defaults: NPP = 4, LVL = 2, LAT = 4.
- Throughput: 1 result per cycle while out_ready = 1.
- Output hold: out_result, out_fmt, out_tag and out_ovf stay stable while out_valid && !out_ready.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_* to out_*.
- Reset (rst_n low, at any time including mid-stream):
  - All valid bits clear immediately; in-flight transactions are discarded.
  - out_valid = 0, out_result = 0, out_fmt = 0, out_tag = 0, out_ovf = 0.
  - in_ready = 1 from the first cycle after reset release.
- Simultaneous output pop and input accept in one cycle is legal and loses nothing.
- Edge operands:
  - Most-negative two's-complement operands (-2^(A_W-1), -2^(B_W-1)) are exact.
  - The maximum positive product fits in P_W bits.

## Configuration
- BOOTH_MULT_SAT_EN defined: on overflow, out_result saturates.
  - fmt 0: clamps to 2^(OUT_W-1)-1 or -2^(OUT_W-1).
  - fmt 1: magnitude clamps to 2^(OUT_W-1)-1, sign kept.
- Not defined: out_result is the low OUT_W bits of the P_W result in the selected format. This is wrap-around.
- out_ovf behaves identically in both builds.

## Test plan
- Defaults, fmt 0: a = -1024, b = -128 -> out_result = 131072 after exactly 4 cycles, out_ovf = 0, tag echoed.
- Defaults, fmt 1: a = 11'h7FF (-1023), b = 8'h7F (+127) -> sign = 1, magnitude = 129921 (19'h5FB81). Then a = 11'h400 (-0), b = 8'h85 (-5) -> out_result = 0.
- OUT_W = 16, fmt 0, a = 1000, b = 100 -> with BOOTH_MULT_SAT_EN: 16'h7FFF, out_ovf = 1. Without it: 16'h86A0, out_ovf = 1.
- Stream 8 back-to-back tagged pairs with out_ready held low for 10 cycles mid-stream -> in_ready = 0 while stalled, outputs stable, all 8 results arrive in order, correct, none lost or duplicated.
- Continuous stream with out_ready = 1 -> one result per cycle; simultaneous pop and accept every cycle.
- Assert rst_n low for 1 cycle with 3 transactions in flight -> out_valid = 0 immediately, no stale results after release, and the next input completes in 4 cycles.
